// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: issue/collect stage in front of a sequential shift-add multiplier.
// Ports:
//   clk, clr              clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b are the operands
//   mul_a, mul_b          registered operands to the multiplier
//   mul_start             one-cycle start pulse to the multiplier
//   mul_p                 product from the multiplier
//   out_valid/out_ready   result handshake; out_p is the captured product
//   result_cnt            results consumed downstream, wraps
module mult_issue_ctrl #(
  parameter int WIDTH       = 4,
  parameter int MUL_LATENCY = 10,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  output logic                   mul_start,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     out_p,
  output logic [CNT_WIDTH-1:0]   result_cnt
);
  localparam int LW = MUL_LATENCY > 1 ? $clog2(MUL_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_M1 = LW'(MUL_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} state_t;
  state_t state, state_nx;
  logic [LW-1:0] count;
  logic accept, zero_op;
  always_ff @(posedge clk or negedge clr)
    if (!clr) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    in_ready  = state == IDLE;
    mul_start = state == START;
    out_valid = state == RESULT;
    accept    = in_valid && state == IDLE;
    zero_op   = in_a == '0 || in_b == '0;
    state_nx  = state;
    case (state)
      IDLE:    state_nx = in_valid ? (zero_op ? RESULT : START) : IDLE;
      START:   state_nx = WAIT;
      WAIT:    state_nx = count == '0 ? RESULT : WAIT;
      default: state_nx = out_ready ? IDLE : RESULT;
    endcase
  end
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      mul_a      <= '0;
      mul_b      <= '0;
      out_p      <= '0;
      count      <= '0;
      result_cnt <= '0;
    end else begin
      if (accept) begin
        mul_a <= in_a;
        mul_b <= in_b;
        // zero operand: product is known, skip the multiplier entirely
        if (zero_op) out_p <= '0;
      end
      if (state == START) count <= LAT_M1;
      else if (state == WAIT) count <= count - 1'b1;
      if (state == WAIT && count == '0) out_p <= mul_p;
      if (state == RESULT && out_ready) result_cnt <= result_cnt + 1'b1;
    end
endmodule
